// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared video timing states, 1080p60 constants and helpers
//
// Contents:
//   h_state_t / ST_*   : horizontal (and reusable vertical) segment state encoding
//   *_1080P            : 1920x1080p60 horizontal and vertical timing constants
//   h_total()          : total clocks per line from the four segment lengths

package video_timing_pkg;

    typedef logic [2:0] h_state_t;

    localparam h_state_t ST_IDLE   = 3'd0;
    localparam h_state_t ST_ACTIVE = 3'd1;
    localparam h_state_t ST_FRONT  = 3'd2;
    localparam h_state_t ST_SYNC   = 3'd3;
    localparam h_state_t ST_BACK   = 3'd4;

    localparam int H_ACTIVE_1080P      = 1920;
    localparam int H_FRONT_PORCH_1080P = 88;
    localparam int H_SYNC_WIDTH_1080P  = 44;
    localparam int H_BACK_PORCH_1080P  = 148;
    localparam int V_ACTIVE_1080P      = 1080;
    localparam int V_TOTAL_1080P       = 1125;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/line_counter.sv
// rtl/line_counter.sv - line index counter advanced by the end-of-line strobe, wraps at vTotal
//
// Ports:
//   clk_i        : pixel clock
//   reset_n_i    : synchronous active-low reset
//   clear_i      : synchronous clear (generator going idle)
//   line_end_i   : one-cycle end-of-line strobe; count advances on the edge where it is high
//   count_o      : current line index 0..vTotal-1

module line_counter #(
    parameter int busWidth = 12,
    parameter int vTotal   = 1125
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                line_end_i,
    output logic [busWidth-1:0] count_o
);

    localparam logic [busWidth-1:0] LAST_LINE = busWidth'(vTotal - 1);

    if (vTotal < 1 || longint'(vTotal - 1) > ((longint'(1) << busWidth) - 1)) begin : g_param_err
        $error("line_counter: vTotal must be >= 1 and vTotal-1 must fit in busWidth bits");
    end

    logic [busWidth-1:0] count_q;
    logic [busWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (line_end_i) begin
            count_d = (count_q == LAST_LINE) ? '0 : count_q + busWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hsync_timing_gen.sv
// rtl/hsync_timing_gen.sv - horizontal video timing generator (ACTIVE/FRONT/SYNC/BACK per line)
//
// Optional feature macro: HSYNC_LINE_COUNT_EN (adds parameter vTotal and output lineCount).
//
// Ports:
//   pixelClock   : pixel clock, all logic on its rising edge
//   reset_n      : synchronous active-low reset
//   enable       : run request; low returns the generator to IDLE
//   hSyncPulse   : horizontal sync, equals syncPolarity during SYNC
//   hActiveVideo : high during ACTIVE
//   hPixelCount  : pixel index within ACTIVE, 0 elsewhere
//   lineEnd      : one-cycle strobe on the last clock of BACK
//   lineCount    : (HSYNC_LINE_COUNT_EN only) line index, wraps at vTotal

module hsync_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   busWidth     = 12,
    parameter int   hActive      = H_ACTIVE_1080P,
    parameter int   hFrontPorch  = H_FRONT_PORCH_1080P,
    parameter int   hSyncWidth   = H_SYNC_WIDTH_1080P,
    parameter int   hBackPorch   = H_BACK_PORCH_1080P,
    parameter logic syncPolarity = 1'b1
`ifdef HSYNC_LINE_COUNT_EN
    ,
    parameter int   vTotal       = V_TOTAL_1080P
`endif
) (
    input  logic                pixelClock,
    input  logic                reset_n,
    input  logic                enable,
    output logic                hSyncPulse,
    output logic                hActiveVideo,
    output logic [busWidth-1:0] hPixelCount,
    output logic                lineEnd
`ifdef HSYNC_LINE_COUNT_EN
    ,
    output logic [busWidth-1:0] lineCount
`endif
);

    localparam int H_TOTAL = h_total(hActive, hFrontPorch, hSyncWidth, hBackPorch);

    localparam logic [busWidth-1:0] ACT_LAST   = busWidth'(hActive - 1);
    localparam logic [busWidth-1:0] FRONT_LAST = busWidth'(hFrontPorch - 1);
    localparam logic [busWidth-1:0] SYNC_LAST  = busWidth'(hSyncWidth - 1);
    localparam logic [busWidth-1:0] BACK_LAST  = busWidth'(hBackPorch - 1);

    if (hActive < 1 || hFrontPorch < 1 || hSyncWidth < 1 || hBackPorch < 1) begin : g_seg_err
        $error("hsync_timing_gen: hActive, hFrontPorch, hSyncWidth and hBackPorch must all be >= 1");
    end

    if (longint'(H_TOTAL - 1) > ((longint'(1) << busWidth) - 1)) begin : g_width_err
        $error("hsync_timing_gen: busWidth too small to hold hTotal-1");
    end

    h_state_t            state_q;
    h_state_t            state_d;
    logic [busWidth-1:0] seg_q;
    logic [busWidth-1:0] seg_d;

    logic                hsync_q;
    logic                active_q;
    logic [busWidth-1:0] pixel_q;
    logic                line_end_q;

    // Next state and segment count. Every state entry restarts seg_d at 0;
    // otherwise the count advances by one within the segment.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q + busWidth'(1);
        if (!enable) begin
            state_d = ST_IDLE;
            seg_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACTIVE;
                    seg_d   = '0;
                end
                ST_ACTIVE: begin
                    if (seg_q == ACT_LAST) begin
                        state_d = ST_FRONT;
                        seg_d   = '0;
                    end
                end
                ST_FRONT: begin
                    if (seg_q == FRONT_LAST) begin
                        state_d = ST_SYNC;
                        seg_d   = '0;
                    end
                end
                ST_SYNC: begin
                    if (seg_q == SYNC_LAST) begin
                        state_d = ST_BACK;
                        seg_d   = '0;
                    end
                end
                ST_BACK: begin
                    if (seg_q == BACK_LAST) begin
                        state_d = ST_ACTIVE;
                        seg_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    seg_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered outputs land
    // on the same edge as the state they describe.
    always_ff @(posedge pixelClock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            hsync_q    <= ~syncPolarity;
            active_q   <= 1'b0;
            pixel_q    <= '0;
            line_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            hsync_q    <= (state_d == ST_SYNC) ? syncPolarity : ~syncPolarity;
            active_q   <= (state_d == ST_ACTIVE);
            pixel_q    <= (state_d == ST_ACTIVE) ? seg_d : '0;
            line_end_q <= (state_d == ST_BACK) && (seg_d == BACK_LAST);
        end
    end

    assign hSyncPulse   = hsync_q;
    assign hActiveVideo = active_q;
    assign hPixelCount  = pixel_q;
    assign lineEnd      = line_end_q;

`ifdef HSYNC_LINE_COUNT_EN
    line_counter #(
        .busWidth (busWidth),
        .vTotal   (vTotal)
    ) u_line_counter (
        .clk_i      (pixelClock),
        .reset_n_i  (reset_n),
        .clear_i    (state_d == ST_IDLE),
        .line_end_i (line_end_q),
        .count_o    (lineCount)
    );
`endif

endmodule
